uart_tx: RTL

//  Serialises PAYLOAD_BITS-wide words onto the UART transmit pin, LSB first, framed

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_bit_timer.sv | 25 ++
 rtl/uart_tx.sv | 106 ++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: bit-timing derivation, parity encodings and the
// FSM state encoding used by the transmitter (and its receive-side partner).
package uart_tx_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Period-based derivation so tx and rx round identically (5208 at 50 MHz / 9600).
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return (1_000_000_000 / bit_rate) / (1_000_000_000 / clk_hz);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Core-side transmit interface: valid/ready word handshake, enable, break
// request, status and the serial pin.
interface uart_tx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_tx_en;
  logic                    uart_tx_valid;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_ready;
  logic                    uart_tx_break;
  logic                    uart_tx_busy;
  logic                    uart_txd;

  modport master (
    output uart_tx_en, uart_tx_valid, uart_tx_data, uart_tx_break,
    input  uart_tx_ready, uart_tx_busy, uart_txd
  );

  modport slave (
    input  uart_tx_en, uart_tx_valid, uart_tx_data, uart_tx_break,
    output uart_tx_ready, uart_tx_busy, uart_txd
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles within one bit and pulses bit_tick on
// the last cycle of each bit. clr holds the count at zero so every bit that
// follows a clear starts on a full period.
module uart_bit_timer #(
  parameter int CYCLES_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_tick
);
  localparam int CW = 1 + $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] cyc_q;

  assign bit_tick = !clr && (cyc_q == LAST);

  // Cycle counter: wraps to zero on the last cycle of each bit.
  always_ff @(posedge clk) begin
    if (reset || clr)  cyc_q <= '0;
    else if (bit_tick) cyc_q <= '0;
    else               cyc_q <= cyc_q + 1'b1;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises words LSB first with start bit, optional
// parity and stop bits, and drives line BREAK on request. The pin is
// registered from the current state, so it follows the state by one cycle.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave tx
);
  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  // Break must last PAYLOAD_BITS+2 whole bits: exit allowed on the tick that
  // completes that bit, i.e. once that many-minus-one ticks are already counted.
  localparam logic [3:0] BRK_MIN   = 4'(PAYLOAD_BITS + 1);

  uart_state_e             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, data_q;
  logic [3:0]              bit_q;
  logic                    txd_q, txd_d, busy_q;
  logic                    bit_tick, accept, start_brk;

  assign tx.uart_tx_ready = !reset && tx.uart_tx_en && (state_q == ST_IDLE) && !tx.uart_tx_break;
  assign accept           = tx.uart_tx_valid && tx.uart_tx_ready;
  assign start_brk        = (state_q == ST_IDLE) && tx.uart_tx_en && tx.uart_tx_break;
  assign tx.uart_txd      = txd_q;
  assign tx.uart_tx_busy  = busy_q;

  // Timer idles at zero in IDLE; all later state changes land on bit ticks.
  uart_bit_timer #(
    .CYCLES_PER_BIT (CPB)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q == ST_IDLE),
    .bit_tick (bit_tick)
  );

  // Next-state and line level for the current state.
  always_comb begin
    state_d = state_q;
    txd_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_brk)   state_d = ST_BREAK;
        else if (accept) state_d = ST_START;
      end
      ST_START: begin
        txd_d = 1'b0;
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        txd_d = shift_q[0];
        if (bit_tick && bit_q == LAST_DATA)
          state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        txd_d = (PARITY == PARITY_EVEN) ? ^data_q : ~^data_q;
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick && bit_q == LAST_STOP) state_d = ST_IDLE;
      end
      ST_BREAK: begin
        txd_d = 1'b0;
        if (bit_tick && bit_q >= BRK_MIN && !tx.uart_tx_break) state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pin, busy, bit counter and word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      busy_q  <= (state_d != ST_IDLE);
      // Bit counter restarts on every state change; saturates in a long break.
      if (state_d != state_q)
        bit_q <= '0;
      else if (bit_tick && !(state_q == ST_BREAK && bit_q == 4'hF))
        bit_q <= bit_q + 4'd1;
      // data_q keeps the whole word for parity; shift_q is consumed bit by bit.
      if (accept) begin
        shift_q <= tx.uart_tx_data;
        data_q  <= tx.uart_tx_data;
      end else if (state_q == ST_DATA && bit_tick) begin
        shift_q <= shift_q >> 1;
      end
    end
  end
endmodule
